// File: rtl/bp_nonsynth_stall_attributor.sv
`timescale 1ns/1ps
// Purpose: attributes every unfrozen commit-point cycle to one histogram bin and streams epoch snapshots out.
// Latency: an event reaches binning num_stages_p cycles after injection; a snapshot starts the cycle after epoch end.
// Backpressure: dump outputs hold while dump_ready_i is low; an epoch end during a dump drops that snapshot and sets overrun_o.
module bp_nonsynth_stall_attributor #(
    parameter int num_events_p   = 21,
    parameter int num_stages_p   = 8,
    parameter logic [num_stages_p*num_events_p-1:0] stage_mask_p = '1,
    parameter int cnt_width_p    = 32,
    parameter int epoch_cycles_p = 0,
    localparam int bin_id_width_lp = ((num_events_p + 2) > 1) ? $clog2(num_events_p + 2) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_li,
    input  logic                       freeze_i,
    input  logic [num_events_p-1:0]    event_i,
    input  logic                       commit_v_i,
    input  logic                       flush_i,
    output logic                       dump_v_o,
    input  logic                       dump_ready_i,
    output logic [bin_id_width_lp-1:0] dump_bin_o,
    output logic [cnt_width_p-1:0]     dump_count_o,
    output logic                       dump_last_o,
    output logic                       overrun_o
);

    localparam int num_bins_lp    = num_events_p + 2;
    localparam int unknown_bin_lp = num_events_p;
    localparam int commit_bin_lp  = num_events_p + 1;
    localparam int epoch_width_lp = (epoch_cycles_p > 1) ? $clog2(epoch_cycles_p) : 1;

    typedef enum logic {
        st_idle,
        st_dump
    } state_e;

    // ------------------------------------------------------------------
    // Shadow pipeline: each stage ORs in the events masked onto it.
    // ------------------------------------------------------------------
    logic [num_events_p-1:0] stage_r [num_stages_p];
    logic [num_events_p-1:0] stage_n [num_stages_p];

    for (genvar s = 0; s < num_stages_p; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign stage_n[s] = event_i & stage_mask_p[s*num_events_p +: num_events_p];
        end else begin : g_body
            assign stage_n[s] = stage_r[s-1] | (event_i & stage_mask_p[s*num_events_p +: num_events_p]);
        end
    end

    // Pipeline shifts every cycle, frozen or not, so stale events drain out.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int s = 0; s < num_stages_p; s++) begin
                stage_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < num_stages_p; s++) begin
                stage_r[s] <= stage_n[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Bin select at the commit point: commit beats any stall reason,
    // lowest event index wins among reasons, otherwise unknown.
    // ------------------------------------------------------------------
    logic [num_events_p-1:0]    head;
    logic [bin_id_width_lp-1:0] sel;

    assign head = stage_r[num_stages_p-1];

    // Priority encode the oldest stage into a single bin index.
    always_comb begin
        sel = bin_id_width_lp'(unknown_bin_lp);
        for (int e = num_events_p - 1; e >= 0; e--) begin
            if (head[e]) begin
                sel = bin_id_width_lp'(e);
            end
        end
        if (commit_v_i) begin
            sel = bin_id_width_lp'(commit_bin_lp);
        end
    end

    // ------------------------------------------------------------------
    // Live bins plus this cycle's saturating increment. The incremented
    // view is what a closing epoch snapshots, so the final cycle counts.
    // ------------------------------------------------------------------
    logic [cnt_width_p-1:0] live_r   [num_bins_lp];
    logic [cnt_width_p-1:0] live_inc [num_bins_lp];

    // Add one to the selected bin unless frozen or already saturated.
    always_comb begin
        for (int b = 0; b < num_bins_lp; b++) begin
            live_inc[b] = live_r[b];
            if (!freeze_i && (sel == bin_id_width_lp'(b)) && (live_r[b] != '1)) begin
                live_inc[b] = live_r[b] + cnt_width_p'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Epoch boundary: explicit flush, or the cycle budget running out.
    // ------------------------------------------------------------------
    logic [epoch_width_lp-1:0] epoch_cnt_r;
    logic                      epoch_wrap;
    logic                      epoch_end;

    if (epoch_cycles_p > 0) begin : g_epoch
        assign epoch_wrap = ~freeze_i & (epoch_cnt_r == epoch_width_lp'(epoch_cycles_p - 1));
    end else begin : g_no_epoch
        assign epoch_wrap = 1'b0;
    end

    assign epoch_end = flush_i | epoch_wrap;

    // Epoch counter advances only on unfrozen cycles and restarts at each boundary.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            epoch_cnt_r <= '0;
        end else if (epoch_end) begin
            epoch_cnt_r <= '0;
        end else if (!freeze_i) begin
            epoch_cnt_r <= epoch_cnt_r + epoch_width_lp'(1);
        end
    end

    // Live bins accumulate, and always clear at an epoch boundary even if the snapshot is dropped.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int b = 0; b < num_bins_lp; b++) begin
                live_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < num_bins_lp; b++) begin
                live_r[b] <= epoch_end ? '0 : live_inc[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Dump FSM: walks the shadow copy one bin per accepted beat.
    // ------------------------------------------------------------------
    state_e                     state_r, state_n;
    logic [bin_id_width_lp-1:0] idx_r, idx_n, idx_inc;
    logic [cnt_width_p-1:0]     count_r, count_n;
    logic                       last_r, last_n;
    logic                       hs, last_hs, take;
    logic [cnt_width_p-1:0]     shadow_r [num_bins_lp];
    logic                       overrun_r;

    assign idx_inc = idx_r + bin_id_width_lp'(1);

    // Next-state and next dump-beat; a final beat coinciding with an epoch end chains straight into the new snapshot.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        count_n = count_r;
        last_n  = last_r;
        hs      = (state_r == st_dump) & dump_ready_i;
        last_hs = hs & last_r;
        take    = epoch_end & ((state_r == st_idle) | last_hs);
        if (take) begin
            state_n = st_dump;
            idx_n   = '0;
            count_n = live_inc[0];
            last_n  = 1'b0;
        end else if (last_hs) begin
            state_n = st_idle;
            idx_n   = '0;
            count_n = '0;
            last_n  = 1'b0;
        end else if (hs) begin
            idx_n   = idx_inc;
            count_n = shadow_r[idx_inc];
            last_n  = (idx_inc == bin_id_width_lp'(commit_bin_lp));
        end
    end

    // FSM state and registered dump outputs.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_r <= st_idle;
            idx_r   <= '0;
            count_r <= '0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            count_r <= count_n;
            last_r  <= last_n;
        end
    end

    // Shadow copy is only overwritten when the previous snapshot has fully drained.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int b = 0; b < num_bins_lp; b++) begin
                shadow_r[b] <= '0;
            end
        end else if (take) begin
            for (int b = 0; b < num_bins_lp; b++) begin
                shadow_r[b] <= live_inc[b];
            end
        end
    end

    // Sticky flag for any epoch whose snapshot could not be captured.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            overrun_r <= 1'b0;
        end else if (epoch_end && !take) begin
            overrun_r <= 1'b1;
        end
    end

    assign dump_v_o     = (state_r == st_dump);
    assign dump_bin_o   = idx_r;
    assign dump_count_o = count_r;
    assign dump_last_o  = last_r;
    assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_bp_nonsynth_stall_attributor.sv
`timescale 1ns/1ps
// Bench for the stall attributor: directed epochs followed by random traffic against a reference model.
// Latency: model predicts each dump beat on the cycle after the clock edge that produces it.
// Backpressure: dump_ready_i is driven low in directed and random phases to exercise hold and overrun.
module tb_bp_nonsynth_stall_attributor;

    localparam int E     = 4;
    localparam int S     = 3;
    localparam logic [S*E-1:0] MASK = 12'h825;  // stage0: e0,e2  stage1: e1  stage2: e3
    localparam int CW    = 3;
    localparam int EPOCH = 12;
    localparam int BW    = 3;
    localparam int NB    = E + 2;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          reset_li;
    logic          freeze_i;
    logic [E-1:0]  event_i;
    logic          commit_v_i;
    logic          flush_i;
    logic          dump_v_o;
    logic          dump_ready_i;
    logic [BW-1:0] dump_bin_o;
    logic [CW-1:0] dump_count_o;
    logic          dump_last_o;
    logic          overrun_o;

    bp_nonsynth_stall_attributor #(
        .num_events_p   (E),
        .num_stages_p   (S),
        .stage_mask_p   (MASK),
        .cnt_width_p    (CW),
        .epoch_cycles_p (EPOCH)
    ) dut (
        .clk_i        (clk_i),
        .reset_li     (reset_li),
        .freeze_i     (freeze_i),
        .event_i      (event_i),
        .commit_v_i   (commit_v_i),
        .flush_i      (flush_i),
        .dump_v_o     (dump_v_o),
        .dump_ready_i (dump_ready_i),
        .dump_bin_o   (dump_bin_o),
        .dump_count_o (dump_count_o),
        .dump_last_o  (dump_last_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int bin;
        int cnt;
    } item_t;

    // Reference model state: history of raw events, bin totals, epoch position, pending dump beats.
    item_t        exp_q[$];
    logic [E-1:0] hist [S];
    int           m_bins [NB];
    int           m_ecnt;
    bit           m_ovr;
    int           got [8];
    int           n_chk  = 0;
    int           n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [E-1:0] mstage(input int s);
        logic [S*E-1:0] mv;
        mv = MASK;
        return mv[s*E +: E];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int j = 0; j < S; j++) hist[j] = '0;
        for (int b = 0; b < NB; b++) m_bins[b] = 0;
        m_ecnt = 0;
        m_ovr  = 1'b0;
    endtask

    task automatic clear_got();
        for (int i = 0; i < 8; i++) got[i] = -1;
    endtask

    task automatic check_outputs();
        check_val("dump_v", dump_v_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_val("dump_bin", dump_bin_o, exp_q[0].bin);
            check_val("dump_count", dump_count_o, exp_q[0].cnt);
            check_val("dump_last", dump_last_o, exp_q[0].bin == NB - 1);
        end
        check_val("overrun", overrun_o, m_ovr);
    endtask

    // One clock: drive inputs, advance the model by the same rules, then compare.
    task automatic step(input logic [E-1:0] ev, input logic cm, input logic fz,
                        input logic fl, input logic rd);
        logic [E-1:0] top;
        int           sel;
        bit           hs;
        bit           ee;
        event_i      = ev;
        commit_v_i   = cm;
        freeze_i     = fz;
        flush_i      = fl;
        dump_ready_i = rd;
        hs = (exp_q.size() != 0) && rd;
        if (hs && !$isunknown(dump_bin_o)) got[dump_bin_o] = int'(dump_count_o);
        @(posedge clk_i);
        // An event seen j cycles ago now sits in stage S-1 if it was injected at stage S-1-j.
        top = '0;
        for (int j = 0; j < S; j++) top = top | (hist[j] & mstage(S - 1 - j));
        sel = E;
        for (int e = 0; e < E; e++) begin
            if (top[e]) begin
                sel = e;
                break;
            end
        end
        if (cm) sel = E + 1;
        if (!fz && m_bins[sel] < SAT) m_bins[sel]++;
        ee = fl || (!fz && m_ecnt == EPOCH - 1);
        if (ee) m_ecnt = 0;
        else if (!fz) m_ecnt++;
        if (hs) void'(exp_q.pop_front());
        if (ee) begin
            if (exp_q.size() == 0) begin
                for (int b = 0; b < NB; b++) exp_q.push_back('{bin: b, cnt: m_bins[b]});
            end else begin
                m_ovr = 1'b1;
            end
            for (int b = 0; b < NB; b++) m_bins[b] = 0;
        end
        for (int j = S - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = ev;
        #1;
        check_outputs();
    endtask

    // Frozen, fully-ready cycles: lets a snapshot stream out without touching the next epoch.
    task automatic drain();
        repeat (8) step('0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        reset_li     = 1'b0;
        freeze_i     = 1'b0;
        event_i      = '0;
        commit_v_i   = 1'b0;
        flush_i      = 1'b0;
        dump_ready_i = 1'b1;
        model_reset();
        clear_got();
        #1;
        check_val("rst_dump_v", dump_v_o, 0);
        check_val("rst_dump_bin", dump_bin_o, 0);
        check_val("rst_dump_count", dump_count_o, 0);
        check_val("rst_dump_last", dump_last_o, 0);
        check_val("rst_overrun", overrun_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_li = 1'b1;

        // Single e0 event: three unknown cycles before it lands, then flush on the cycle it is counted.
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check_val("A_bin0", got[0], 1);
        check_val("A_bin4", got[4], 3);
        check_val("A_bin5", got[5], 0);
        clear_got();

        // e0 and e2 together: lower index wins.
        step(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check_val("B_bin0", got[0], 1);
        check_val("B_bin2", got[2], 0);
        check_val("B_bin4", got[4], 3);
        clear_got();

        // Commit on every cycle overrides the arriving stall event.
        step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        check_val("C_bin0", got[0], 0);
        check_val("C_bin5", got[5], 4);
        clear_got();

        // Twelve unknown cycles: the epoch closes on its own and the 3-bit bin saturates.
        repeat (EPOCH) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check_val("D_bin4_sat", got[4], SAT);
        check_val("D_bin5", got[5], 0);
        clear_got();

        // Consumer stalled across a second flush: that snapshot is dropped, the first survives.
        step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("E_overrun", overrun_o, 1);
        repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("E_held_bin", dump_bin_o, 0);
        drain();
        check_val("E_bin4", got[4], 1);
        check_val("E_bin5", got[5], 0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        // Reset while a snapshot is being held: outputs drop without waiting for a clock.
        step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_li = 1'b0;
        #1;
        check_val("R_dump_v", dump_v_o, 0);
        check_val("R_overrun", overrun_o, 0);
        check_val("R_dump_bin", dump_bin_o, 0);
        check_val("R_dump_count", dump_count_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        reset_li = 1'b1;
        repeat (4) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
